// File: rtl/program_loader_if.sv
// program_loader_if: valid/ready instruction-word stream from the host configuration
// bus into the program loader.
//   in_valid  host has an instruction word available
//   in_data   instruction word
//   in_ready  loader accepts the word this cycle
// Modports: master = host (drives valid/data), slave = loader (drives ready).
interface program_loader_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 in_valid;
  logic [DataWidth-1:0] in_data;
  logic                 in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: writes a stream of instruction words into consecutive instruction-memory
// addresses starting at 0, then hands the program counter its max/loop addresses and enable.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   start_i        one-cycle request to begin a load (honoured in idle or run)
//   last_addr_i    address of final instruction, sampled on accepted start
//   loop_addr_i    PC wrap target, sampled on accepted start
//   stop_i         abort to idle and drop pc_en (wins over start)
//   in_if          instruction-word stream (slave side)
//   mem_we_o/mem_addr_o/mem_wdata_o  instruction-memory write port, one cycle after handshake
//   pc_max_o/pc_loop_o/pc_en_o       program-counter configuration
//   busy_o/done_o  load in progress / program loaded and running
//   cfg_err_o      loop_addr exceeded last_addr at the last accepted start
module program_loader #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] last_addr_i,
  input  logic [AddrWidth-1:0] loop_addr_i,
  input  logic                 stop_i,
  program_loader_if.slave      in_if,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [AddrWidth-1:0] pc_max_o,
  output logic [AddrWidth-1:0] pc_loop_o,
  output logic                 pc_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_err_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   cnt_q;
  logic                   in_ready_q;
  logic                   mem_we_q;
  logic [AddrWidth-1:0]   mem_addr_q;
  logic [DataWidth-1:0]   mem_wdata_q;
  logic [AddrWidth-1:0]   pc_max_q;
  logic [AddrWidth-1:0]   pc_loop_q;
  logic                   pc_en_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   cfg_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pc_max_q    <= '0;
      pc_loop_q   <= '0;
      pc_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (stop_i) begin
        // Any handshake this cycle is dropped; pc_max/pc_loop/cfg_err keep their values.
        state_q    <= StIdle;
        in_ready_q <= 1'b0;
        pc_en_q    <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StRun: begin
            if (start_i) begin
              state_q    <= StLoad;
              cnt_q      <= '0;
              pc_max_q   <= last_addr_i;
              in_ready_q <= 1'b1;
              pc_en_q    <= 1'b0;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              if (loop_addr_i <= last_addr_i) begin
                pc_loop_q <= loop_addr_i;
                cfg_err_q <= 1'b0;
              end else begin
                pc_loop_q <= '0;
                cfg_err_q <= 1'b1;
              end
            end
          end
          StLoad: begin
            if (in_if.in_valid && in_ready_q) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= cnt_q;
              mem_wdata_q <= in_if.in_data;
              cnt_q       <= cnt_q + 1'b1;
              // Compare before increment so a full-size program never wraps early.
              if (cnt_q == pc_max_q) begin
                state_q    <= StRun;
                in_ready_q <= 1'b0;
                pc_en_q    <= 1'b1;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign pc_max_o       = pc_max_q;
  assign pc_loop_o      = pc_loop_q;
  assign pc_en_o        = pc_en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign cfg_err_o      = cfg_err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader. Expected values
// come from the program's word list (address i receives word i, one cycle after acceptance)
// and the range rule for loop_addr.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [3:0]  last_addr;
  logic [3:0]  loop_addr;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  pc_max;
  logic [3:0]  pc_loop;
  logic        pc_en;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  program_loader_if #(.DataWidth(32)) in_if ();

  program_loader #(
    .AddrWidth(4),
    .DataWidth(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .last_addr_i(last_addr),
    .loop_addr_i(loop_addr),
    .stop_i     (stop),
    .in_if      (in_if.slave),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .pc_max_o   (pc_max),
    .pc_loop_o  (pc_loop),
    .pc_en_o    (pc_en),
    .busy_o     (busy),
    .done_o     (done),
    .cfg_err_o  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_ready", 32'(in_if.in_ready), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_pc_max", 32'(pc_max), 32'd0);
    check("rst_pc_loop", 32'(pc_loop), 32'd0);
  endtask

  // mode 0: valid always high, data 0xA0+i; mode 1: valid 1,0,1,0...; else random gaps/data.
  task automatic run_load(input int last, input int loop, input int mode);
    int          words = last + 1;
    int          sent  = 0;
    int          cyc   = 0;
    int          exp_loop;
    logic        v;
    logic [31:0] d;
    exp_loop  = (loop <= last) ? loop : 0;
    start     = 1'b1;
    last_addr = last[3:0];
    loop_addr = loop[3:0];
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_pc_en", 32'(pc_en), 32'd0);
    check("start_ready", 32'(in_if.in_ready), 32'd1);
    check("pc_max", 32'(pc_max), 32'(last));
    check("pc_loop", 32'(pc_loop), 32'(exp_loop));
    check("cfg_err", 32'(cfg_err), 32'(loop > last));
    while (sent < words && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      d = (mode == 0) ? 32'hA0 + 32'(sent) : $urandom;
      in_if.in_valid = v;
      in_if.in_data  = d;
      tick();
      cyc++;
      check("mem_we", 32'(mem_we), 32'(v));
      if (v) begin
        check("mem_addr", 32'(mem_addr), 32'(sent));
        check("mem_wdata", mem_wdata, d);
        sent++;
      end
      check("done", 32'(done), 32'(sent == words));
      check("pc_en", 32'(pc_en), 32'(sent == words));
      check("busy", 32'(busy), 32'(sent != words));
      check("in_ready", 32'(in_if.in_ready), 32'(sent != words));
    end
    check("load_len", 32'(sent), 32'(words));
    // Extra offered words must never be written.
    in_if.in_valid = 1'b1;
    in_if.in_data  = $urandom;
    repeat (2) begin
      tick();
      check("post_we", 32'(mem_we), 32'd0);
      check("post_ready", 32'(in_if.in_ready), 32'd0);
      check("post_done", 32'(done), 32'd1);
    end
    in_if.in_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    last_addr      = '0;
    loop_addr      = '0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_values();

    run_load(3, 1, 0);
    run_load(3, 1, 1);
    run_load(15, 0, 0);
    run_load(2, 5, 2);
    for (int i = 0; i < 4; i++) begin
      run_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 2);
    end
    // Reload from RUN with a single-word program.
    run_load(0, 0, 0);

    // Simultaneous start and stop in RUN: stop wins, configuration holds.
    run_load(4, 2, 2);
    start     = 1'b1;
    stop      = 1'b1;
    last_addr = 4'd9;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_done", 32'(done), 32'd0);
    check("ss_pc_en", 32'(pc_en), 32'd0);
    check("ss_ready", 32'(in_if.in_ready), 32'd0);
    check("ss_pc_max", 32'(pc_max), 32'd4);

    // Stop after 2 of 4 words; the word offered with stop is discarded.
    start     = 1'b1;
    last_addr = 4'd3;
    loop_addr = 4'd1;
    tick();
    start          = 1'b0;
    in_if.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_if.in_data = 32'h100 + 32'(i);
      tick();
      check("stop_we", 32'(mem_we), 32'd1);
      check("stop_addr", 32'(mem_addr), 32'(i));
    end
    stop          = 1'b1;
    in_if.in_data = 32'h1FF;
    tick();
    stop           = 1'b0;
    in_if.in_valid = 1'b0;
    check("stop_no_we", 32'(mem_we), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_pc_en", 32'(pc_en), 32'd0);
    check("stop_ready", 32'(in_if.in_ready), 32'd0);
    check("stop_pc_max", 32'(pc_max), 32'd3);
    check("stop_pc_loop", 32'(pc_loop), 32'd1);
    in_if.in_valid = 1'b1;
    tick();
    check("stop_idle_we", 32'(mem_we), 32'd0);
    in_if.in_valid = 1'b0;

    // Reset after 1 word of a load with cfg_err set.
    start     = 1'b1;
    last_addr = 4'd5;
    loop_addr = 4'd9;
    tick();
    start          = 1'b0;
    in_if.in_valid = 1'b1;
    in_if.in_data  = 32'hDEAD;
    tick();
    check("rst_mid_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    in_if.in_valid = 1'b0;
    check_reset_values();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface that the per-PE program counter reads.
- Accepts a stream of instruction words over a valid/ready input and writes them to consecutive instruction-memory addresses starting at 0.
- Then publishes the matching last-address (max) and loop-back address to the program counter and raises its enable.
- Sits between the host configuration bus and each PE's program counter plus instruction memory.

Parameters:
ADDR_WIDTH, 4, width of instruction-memory address, pc_max and pc_loop
DATA_WIDTH, 32, width of one instruction word

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
start  input  1  one-cycle request to begin a new program load
last_addr  input  ADDR_WIDTH  address of final instruction (word count = last_addr+1); sampled on accepted start
loop_addr  input  ADDR_WIDTH  address the PC wraps to after last_addr; sampled on accepted start
stop  input  1  return to IDLE and drop pc_en
in_valid  input  1  instruction word available
in_data  input  DATA_WIDTH  instruction word
in_ready  output  1  loader accepts a word this cycle
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_WIDTH  instruction-memory write address
mem_wdata  output  DATA_WIDTH  instruction-memory write data
pc_max  output  ADDR_WIDTH  max value for the program counter
pc_loop  output  ADDR_WIDTH  loop value for the program counter
pc_en  output  1  enable for the program counter
busy  output  1  load in progress
done  output  1  program loaded and running
cfg_err  output  1  loop_addr was out of range at the last accepted start

Behaviour:
- Single clock domain; all outputs registered.
- Reset (rst=1 at a clk edge):
  - State IDLE; write counter = 0.
  - in_ready, mem_we, pc_en, busy, done and cfg_err = 0.
  - mem_addr, mem_wdata, pc_max and pc_loop = 0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - in_ready=0.
  - start=1 latches last_addr into pc_max and clears the write counter.
  - If loop_addr <= last_addr: latch pc_loop=loop_addr, cfg_err=0. Otherwise: pc_loop=0, cfg_err=1.
  - Then go to LOAD, busy=1 and done=0 from the next cycle.
- LOAD:
  - in_ready=1.
  - Handshake: in_valid && in_ready.
  - On each handshake, the next cycle shows mem_we=1, mem_addr=counter, mem_wdata=in_data; the counter then increments. Write latency is exactly 1 cycle.
  - mem_we=0 in any cycle not following a handshake; mem_addr and mem_wdata hold their last values.
  - The handshake with counter==pc_max is the final word:
    - in_ready drops to 0 the next cycle, together with that final mem_we pulse.
    - The state becomes RUN at that edge, so busy=0, done=1 and pc_en=1 coincide with the final write strobe.
  - No extra word is ever accepted.
- Single-word program: last_addr=0 loads exactly one word.
- Full-size program: last_addr=2^ADDR_WIDTH-1 loads 2^ADDR_WIDTH words. The counter must not wrap before the compare; compare before increment.
- RUN:
  - pc_en=1, done=1, in_ready=0.
  - pc_max and pc_loop hold.
  - start while in RUN begins a new load: identical to start in IDLE, and pc_en drops the next cycle.
- stop=1 in LOAD or RUN:
  - Next cycle: IDLE, pc_en=0, busy=0, done=0, in_ready=0.
  - pc_max, pc_loop and cfg_err hold.
  - A handshake coinciding with stop is discarded (no write).
- Simultaneous start and stop: stop wins.
- start during LOAD is ignored.
- rst mid-load aborts immediately to reset values. Memory contents already written are not this block's concern.

Test Plan:
- ADDR_WIDTH=4. Reset, then start with last_addr=3, loop_addr=1. Stream 0xA0..0xA3 with in_valid held high. Required:
  - mem_we pulses on 4 consecutive cycles, addr 0..3 with data 0xA0..0xA3, each one cycle after its handshake.
  - pc_max=3, pc_loop=1.
  - pc_en=1 and done=1 aligned with the addr-3 write.
  - in_ready=0 afterwards.
- Same load with in_valid toggling 1,0,1,0. Required: mem_we only after accepted words; addresses stay contiguous 0..3; no write for idle beats.
- start with last_addr=15, loop_addr=0, then 16 words. Required: writes to addr 0..15; no wrap-around write to 0; done=1 after the 16th word.
- start with last_addr=2, loop_addr=5. Required: cfg_err=1, pc_loop=0; load still completes after 3 words.
- Mid-load scenarios:
  - stop after 2 of 4 words. Required: IDLE next cycle, pc_en=0, no further mem_we.
  - rst after 1 word. Required: all outputs at reset values on the next cycle.
- In RUN, start with last_addr=0 and one word. Required: pc_en drops for the load, then a single write to addr 0, pc_max=0, pc_en returns to 1.
